wbm_pipelined_cmd: RTL and testbench

Parametrised, pipelined successor to the single-transaction command-word Wishbone master. It translates a host command stream of (DW+2)-bit words into Wishbone B4 pipelined bus cycles, with up to 2^LGOUT-1 requests outstanding and auto-increment/relative addressing. It returns one (DW+2)-bit response per address-set, ack, error or reset, and sits between the host link/debug bridge and the system interconnect.

---
 rtl/wbm_pipelined_cmd.sv | 196 +++++++++++++++++++
 tb/tb_wbm_pipelined_cmd.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbm_pipelined_cmd.sv
// Command-word to Wishbone B4 pipelined master with auto-increment/relative addressing.
// Define BUS_TIMEOUT_EN to build an ack watchdog that aborts a silent bus cycle.
module wbm_pipelined_cmd #(
    parameter int DW      = 32,
    parameter int AW      = 30,
    parameter int LGOUT   = 3,
    parameter int TIMEOUT = 1023
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_cmd_stb,
    input  logic [DW+1:0]   i_cmd_word,
    output logic            o_cmd_busy,
    output logic            o_rsp_stb,
    output logic [DW+1:0]   o_rsp_word,
    output logic            o_wb_cyc,
    output logic            o_wb_stb,
    output logic            o_wb_we,
    output logic [AW-1:0]   o_wb_addr,
    output logic [DW-1:0]   o_wb_data,
    output logic [DW/8-1:0] o_wb_sel,
    input  logic            i_wb_stall,
    input  logic            i_wb_ack,
    input  logic            i_wb_err,
    input  logic [DW-1:0]   i_wb_data
);

    typedef enum logic [1:0] {
        CMD_READ    = 2'b00,
        CMD_WRITE   = 2'b01,
        CMD_SETADDR = 2'b10,
        CMD_BUSRST  = 2'b11
    } cmd_e;

    localparam logic [LGOUT-1:0] CNT_MAX     = '1;
    localparam logic [DW+1:0]    RSP_RESET   = {2'b11, {DW{1'b0}}};
    localparam logic [DW+1:0]    RSP_BUSERR  = {2'b11, 3'h1, {(DW-3){1'b0}}};
    localparam logic [DW+1:0]    RSP_TIMEOUT = {2'b11, 3'h2, {(DW-3){1'b0}}};
    localparam logic [DW+1:0]    RSP_WRACK   = {2'b00, DW'(1)};

    logic             cyc_q, cyc_d, stb_q, stb_d, we_q, we_d, inc_q, inc_d;
    logic [AW-1:0]    addr_q, addr_d, set_addr;
    logic [DW-1:0]    data_q, data_d, payload;
    logic [LGOUT-1:0] cnt_q, cnt_d;
    logic             rsp_stb_q, rsp_stb_d, rst_pend_q, rst_pend_d;
    logic [DW+1:0]    rsp_word_q, rsp_word_d;
    logic             accept, issue, ack_v, err_any, timeout;
    cmd_e             cmd_type;

    assign cmd_type = cmd_e'(i_cmd_word[DW+1:DW]);
    assign payload  = i_cmd_word[DW-1:0];
    assign set_addr = payload[AW+1:2] + (payload[1] ? addr_q : '0);

    // A pending stb at CNT_MAX-1 would overflow the counter once it issues, so hold off one early.
    always_comb begin
        o_cmd_busy = 1'b0;
        if (stb_q && i_wb_stall)
            o_cmd_busy = 1'b1;
        if (cnt_q == CNT_MAX || (stb_q && cnt_q == CNT_MAX - LGOUT'(1)))
            o_cmd_busy = 1'b1;
        if (cyc_q && i_cmd_word[DW+1])
            o_cmd_busy = 1'b1;
        if (cyc_q && !i_cmd_word[DW+1] && (i_cmd_word[DW] != we_q))
            o_cmd_busy = 1'b1;
    end

    assign accept  = i_cmd_stb && !o_cmd_busy;
    assign issue   = stb_q && !i_wb_stall;
    assign err_any = cyc_q && (i_wb_err || timeout);
    assign ack_v   = cyc_q && i_wb_ack && !err_any && (cnt_q != '0 || issue);

`ifdef BUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;

    always_comb begin
        tmo_d   = '0;
        timeout = 1'b0;
        if (cyc_q && cnt_q != '0 && !i_wb_ack) begin
            if (tmo_q == TW'(TIMEOUT - 1))
                timeout = 1'b1;
            else
                tmo_d = tmo_q + TW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            tmo_q <= '0;
        else
            tmo_q <= tmo_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        cyc_d      = cyc_q;
        stb_d      = stb_q;
        we_d       = we_q;
        addr_d     = addr_q;
        data_d     = data_q;
        inc_d      = inc_q;
        rsp_stb_d  = 1'b0;
        rsp_word_d = rsp_word_q;
        rst_pend_d = 1'b0;

        if (issue) begin
            addr_d = addr_q + AW'(inc_q);
            stb_d  = 1'b0;
        end

        if (accept) begin
            case (cmd_type)
                CMD_READ, CMD_WRITE: begin
                    cyc_d = 1'b1;
                    stb_d = 1'b1;
                    we_d  = i_cmd_word[DW];
                    if (i_cmd_word[DW])
                        data_d = payload;
                end
                CMD_SETADDR: begin
                    addr_d     = set_addr;
                    inc_d      = !payload[0];
                    rsp_stb_d  = 1'b1;
                    rsp_word_d = {2'b10, (DW-2)'(set_addr), 1'b0, !payload[0]};
                end
                default: begin
                    addr_d     = '0;
                    inc_d      = 1'b0;
                    rsp_stb_d  = 1'b1;
                    rsp_word_d = RSP_RESET;
                end
            endcase
        end

        cnt_d = cnt_q + LGOUT'(issue) - LGOUT'(ack_v);

        if (ack_v) begin
            rsp_stb_d  = 1'b1;
            rsp_word_d = we_q ? RSP_WRACK : {2'b01, i_wb_data};
        end

        if (cyc_q && cnt_d == '0 && !stb_d)
            cyc_d = 1'b0;

        if (err_any) begin
            cyc_d      = 1'b0;
            stb_d      = 1'b0;
            cnt_d      = '0;
            rsp_stb_d  = 1'b1;
            rsp_word_d = i_wb_err ? RSP_BUSERR : RSP_TIMEOUT;
        end

        if (rst_pend_q) begin
            rsp_stb_d  = 1'b1;
            rsp_word_d = RSP_RESET;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            inc_q      <= 1'b0;
            cnt_q      <= '0;
            rsp_stb_q  <= 1'b0;
            rsp_word_q <= '0;
            rst_pend_q <= 1'b1;
        end else begin
            cyc_q      <= cyc_d;
            stb_q      <= stb_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            inc_q      <= inc_d;
            cnt_q      <= cnt_d;
            rsp_stb_q  <= rsp_stb_d;
            rsp_word_q <= rsp_word_d;
            rst_pend_q <= rst_pend_d;
        end
    end

    assign o_wb_cyc   = cyc_q;
    assign o_wb_stb   = stb_q;
    assign o_wb_we    = we_q;
    assign o_wb_addr  = addr_q;
    assign o_wb_data  = data_q;
    assign o_wb_sel   = '1;
    assign o_rsp_stb  = rsp_stb_q;
    assign o_rsp_word = rsp_word_q;

endmodule

// File: tb/tb_wbm_pipelined_cmd.sv
// Randomised bench for wbm_pipelined_cmd: queue-based host/slave reference model.
module tb_wbm_pipelined_cmd;

    localparam int DW = 32, AW = 30, LGOUT = 3, TMO = 15;
    localparam logic [33:0] RSP_RST = 34'h3_0000_0000;
    localparam logic [33:0] RSP_ERR = 34'h3_2000_0000;
    localparam logic [33:0] RSP_TMO = 34'h3_4000_0000;
    localparam logic [33:0] RSP_WR  = 34'h0_0000_0001;

    logic          clk = 1'b0;
    logic          i_reset, i_cmd_stb, i_wb_stall, i_wb_ack, i_wb_err;
    logic [33:0]   i_cmd_word;
    logic [31:0]   i_wb_data;
    logic          o_cmd_busy, o_rsp_stb, o_wb_cyc, o_wb_stb, o_wb_we;
    logic [33:0]   o_rsp_word;
    logic [29:0]   o_wb_addr;
    logic [31:0]   o_wb_data;
    logic [3:0]    o_wb_sel;

    always #5 clk = ~clk;

    wbm_pipelined_cmd #(.DW(DW), .AW(AW), .LGOUT(LGOUT), .TIMEOUT(TMO)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_cmd_stb(i_cmd_stb), .i_cmd_word(i_cmd_word), .o_cmd_busy(o_cmd_busy),
        .o_rsp_stb(o_rsp_stb), .o_rsp_word(o_rsp_word),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
        .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
        .i_wb_data(i_wb_data)
    );

    typedef struct { logic we; logic [31:0] data; } cmd_t;
    typedef struct { logic we; int unsigned ready; } txn_t;

    cmd_t        cmdq[$];
    txn_t        pend[$];
    logic [29:0] m_addr;
    logic        m_inc, m_we;
    logic        exp_v;
    logic [33:0] exp_w;
    int unsigned ncyc, n_checks, n_fail, lat_min, lat_max;
    bit          stall_en, hold_acks, hold_to7, inj_ack, inj_err, acc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One bus cycle: slave decisions, host handshake, then check registered outputs.
    task automatic step();
        int unsigned outst0, cq0, lat;
        logic        work;
        logic [1:0]  kind;
        logic [31:0] pl, rd;
        logic [29:0] na;
        cmd_t        c;
        txn_t        t;
        outst0 = pend.size();
        cq0    = cmdq.size();
        work   = (outst0 > 0) || (cq0 > 0);
        acc    = 1'b0;
        i_wb_stall = stall_en && ($urandom_range(0, 3) == 0);
        if (cq0 > 0 && !i_wb_stall) begin
            c = cmdq.pop_front();
            chk("issue_we", o_wb_we, c.we);
            chk("issue_addr", o_wb_addr, m_addr);
            if (c.we) chk("issue_data", o_wb_data, c.data);
            m_addr  = m_addr + 30'(m_inc);
            lat     = $urandom_range(lat_min, lat_max);
            t.we    = c.we;
            t.ready = ncyc + lat;
            pend.push_back(t);
        end
        i_wb_ack  = 1'b0;
        i_wb_err  = 1'b0;
        i_wb_data = $urandom();
        if (inj_err) begin
            i_wb_err = 1'b1;
            exp_v = 1'b1;
            exp_w = RSP_ERR;
            pend.delete();
            cmdq.delete();
        end else if (inj_ack) begin
            i_wb_ack = 1'b1;
        end else if (!hold_acks && pend.size() > 0 && pend[0].ready <= ncyc) begin
            t = pend.pop_front();
            rd = $urandom();
            i_wb_ack  = 1'b1;
            i_wb_data = rd;
            exp_v = 1'b1;
            exp_w = t.we ? RSP_WR : {2'b01, rd};
        end
        #1;
        if (outst0 == 7) chk("busy_full", o_cmd_busy, 1);
        if (i_cmd_stb) begin
            kind = i_cmd_word[33:32];
            if (work && kind[1]) chk("busy_nonbus", o_cmd_busy, 1);
            if (work && !kind[1] && kind[0] != m_we) chk("busy_dir", o_cmd_busy, 1);
            if (!work) chk("busy_idle", o_cmd_busy, 0);
            if (!o_cmd_busy) begin
                acc = 1'b1;
                pl  = i_cmd_word[31:0];
                case (kind)
                    2'b00, 2'b01: begin
                        c.we = kind[0];
                        c.data = pl;
                        cmdq.push_back(c);
                        m_we = kind[0];
                    end
                    2'b10: begin
                        na = pl[31:2];
                        if (pl[1]) na = na + m_addr;
                        m_addr = na;
                        m_inc  = !pl[0];
                        exp_v  = 1'b1;
                        exp_w  = {2'b10, na, 1'b0, m_inc};
                    end
                    default: begin
                        m_addr = '0;
                        m_inc  = 1'b0;
                        exp_v  = 1'b1;
                        exp_w  = RSP_RST;
                    end
                endcase
            end
        end
        @(posedge clk);
        @(negedge clk);
        ncyc++;
        chk("rsp_stb", o_rsp_stb, exp_v);
        if (exp_v) chk("rsp_word", o_rsp_word, exp_w);
        exp_v = 1'b0;
        chk("stb", o_wb_stb, cmdq.size() > 0);
        if (cmdq.size() > 0 || pend.size() > 0) chk("cyc_active", o_wb_cyc, 1);
        if (hold_to7 && pend.size() == 7) begin
            hold_acks = 1'b0;
            hold_to7  = 1'b0;
        end
    endtask

    task automatic send(input logic [1:0] kind, input logic [31:0] pl);
        int unsigned n;
        n = 0;
        i_cmd_stb  = 1'b1;
        i_cmd_word = {kind, pl};
        do begin
            step();
            n++;
        end while (!acc && n < 200);
        i_cmd_stb = 1'b0;
        chk("send_accept", acc, 1);
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        i_cmd_stb = 1'b0;
        while ((cmdq.size() > 0 || pend.size() > 0 || o_wb_cyc) && n < 300) begin
            step();
            n++;
        end
        chk("drain_cyc", o_wb_cyc, 0);
    endtask

    initial begin
        int unsigned r, k;
        logic [1:0]  kind;
        n_checks = 0; n_fail = 0; ncyc = 0;
        stall_en = 0; hold_acks = 0; hold_to7 = 0; inj_ack = 0; inj_err = 0;
        lat_min = 1; lat_max = 1; exp_v = 0; exp_w = '0;
        m_addr = '0; m_inc = 1'b0; m_we = 1'b0;
        i_reset = 1'b1; i_cmd_stb = 1'b0; i_cmd_word = '0;
        i_wb_stall = 1'b0; i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_data = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cyc", o_wb_cyc, 0);
        chk("rst_stb", o_wb_stb, 0);
        chk("rst_we", o_wb_we, 0);
        chk("rst_addr", o_wb_addr, 0);
        chk("rst_data", o_wb_data, 0);
        chk("rst_rsp_stb", o_rsp_stb, 0);
        chk("rst_rsp_word", o_rsp_word, 0);
        chk("rst_busy", o_cmd_busy, 0);
        chk("sel", o_wb_sel, 4'hf);
        i_reset = 1'b0;
        exp_v = 1'b1;
        exp_w = RSP_RST;
        step();

        // Four back-to-back reads from 0x40, fixed two-cycle ack latency.
        lat_min = 2; lat_max = 2;
        send(2'b10, 32'h0000_0100);
        for (int i = 0; i < 4; i++) send(2'b00, $urandom());
        drain();
        chk("addr_after_reads", o_wb_addr, 30'h44);

        // Eight writes; slave withholds acks until seven are outstanding.
        lat_min = 1; lat_max = 1;
        hold_acks = 1; hold_to7 = 1;
        for (int i = 0; i < 8; i++) send(2'b01, $urandom());
        drain();
        chk("hold_released", hold_to7, 0);

        // Write presented while a read cycle is still open.
        lat_min = 3; lat_max = 3;
        send(2'b00, $urandom());
        send(2'b01, $urandom());
        drain();

        // Relative addressing, then a read acked in its own issue cycle.
        lat_min = 0; lat_max = 0;
        send(2'b10, 32'h0000_0040);
        send(2'b10, 32'h0000_0012);
        chk("rel_addr", o_wb_addr, 30'h14);
        send(2'b00, $urandom());
        drain();
        chk("addr_after_rel", o_wb_addr, 30'h15);

        // Bus error with three reads outstanding; later acks must be ignored.
        lat_min = 1; lat_max = 1;
        hold_acks = 1;
        for (int i = 0; i < 3; i++) send(2'b00, $urandom());
        k = 0;
        while (pend.size() < 3 && k < 20) begin step(); k++; end
        chk("err_outstanding", pend.size(), 3);
        inj_err = 1;
        step();
        inj_err = 0;
        chk("err_cyc", o_wb_cyc, 0);
        inj_ack = 1;
        repeat (2) step();
        inj_ack = 0;
        hold_acks = 0;

`ifdef BUS_TIMEOUT_EN
        hold_acks = 1;
        send(2'b00, $urandom());
        step();
        i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_stall = 1'b0;
        k = 0;
        while (!o_rsp_stb && k < 40) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        chk("tmo_rsp_stb", o_rsp_stb, 1);
        chk("tmo_rsp_word", o_rsp_word, RSP_TMO);
        chk("tmo_cycles", k, 15);
        chk("tmo_cyc", o_wb_cyc, 0);
        pend.delete();
        hold_acks = 0;
        step();
`endif

        // Random traffic: stalls, variable latency, mixed command types.
        stall_en = 1; lat_min = 0; lat_max = 3;
        for (int i = 0; i < 400; i++) begin
            if (!i_cmd_stb && $urandom_range(0, 2) != 0) begin
                r = $urandom_range(0, 19);
                kind = (r < 8) ? 2'b00 : (r < 16) ? 2'b01 : (r < 19) ? 2'b10 : 2'b11;
                i_cmd_stb  = 1'b1;
                i_cmd_word = {kind, 32'($urandom())};
            end
            step();
            if (acc) i_cmd_stb = 1'b0;
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
